cmd_seq_queue: RTL and testbench

//  Parametrised command sequencer on the host side of the Knight link.
//  - Buffers up to DEPTH 16-bit Knight commands; issues each through RemoteComm (send_cmd/cmd_sent).
//  - Holds each command until the completion response arrives; counts per-move responses.
//  - Replaces hand-sequenced send/wait loops in benches and host logic with one autonomous block.

---
 rtl/kt_seq_pkg.sv | 19 +
 rtl/cmd_fifo.sv | 54 +++++
 rtl/cmd_seq_queue.sv | 148 ++++++++++++++
 tb/tb_cmd_seq_queue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kt_seq_pkg.sv
// rtl/kt_seq_pkg.sv - sequencer state type, default response codes and Knight opcodes
package kt_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_SENT,
    S_WAIT_RESP
  } seq_state_t;

  localparam logic [7:0] DONE_RESP_DEF   = 8'hA5;
  localparam logic [7:0] MOVE_RESP_DEF   = 8'h5A;

  localparam logic [3:0] OP_MOVE         = 4'h4;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'h5;
  localparam logic [3:0] OP_TOUR         = 4'h6;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - DEPTH x W show-ahead FIFO with count/full/empty and flush
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push && (!full || do_pop) && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cmd_seq_queue.sv
// rtl/cmd_seq_queue.sv - queued Knight command sequencer over RemoteComm
// Optional WAIT_RESP watchdog enabled by defining CMD_SEQ_TIMEOUT_EN.
module cmd_seq_queue
  import kt_seq_pkg::*;
#(
  parameter int                DEPTH     = 8,
  parameter int                CMD_W     = 16,
  parameter int                RESP_W    = 8,
  parameter logic [RESP_W-1:0] DONE_RESP = RESP_W'(DONE_RESP_DEF),
  parameter logic [RESP_W-1:0] MOVE_RESP = RESP_W'(MOVE_RESP_DEF)
`ifdef CMD_SEQ_TIMEOUT_EN
  , parameter int              TMO_CYC   = 2**26
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [CMD_W-1:0]       push_cmd,
  input  logic                   start,
  input  logic                   abort,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   send_cmd,
  output logic [CMD_W-1:0]       cmd,
  input  logic                   cmd_sent,
  input  logic                   resp_rdy,
  input  logic [RESP_W-1:0]      resp,
  output logic                   clr_resp_rdy,
  output logic                   busy,
  output logic                   cmd_done,
  output logic                   seq_done,
  output logic [7:0]             move_cnt,
  output logic                   err
);

  seq_state_t       state, nxt;
  logic             fifo_pop, fifo_flush;
  logic             err_set, err_clr, move_inc, tmo_hit;
  logic [CMD_W-1:0] head;

  cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (push),
    .din   (push_cmd),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef CMD_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                tmo_cnt <= '0;
    else if (state != S_WAIT_RESP || resp_rdy) tmo_cnt <= '0;
    else                                       tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (tmo_cnt == 32'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // every response is acknowledged; only WAIT_RESP acts on its value
  assign clr_resp_rdy = resp_rdy;
  assign busy         = (state != S_IDLE);

  always_comb begin
    nxt        = state;
    send_cmd   = 1'b0;
    cmd_done   = 1'b0;
    seq_done   = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    move_inc   = 1'b0;
    if (abort) begin
      nxt        = S_IDLE;
      fifo_flush = 1'b1;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          err_clr = 1'b1;
          if (!empty) nxt = S_LOAD;
          else        seq_done = 1'b1;
        end
        S_LOAD: begin
          fifo_pop = 1'b1;
          nxt      = S_SEND;
        end
        S_SEND: begin
          send_cmd = 1'b1;
          nxt      = S_WAIT_SENT;
        end
        S_WAIT_SENT: if (cmd_sent) nxt = S_WAIT_RESP;
        S_WAIT_RESP: begin
          if (resp_rdy) begin
            if (resp == MOVE_RESP) begin
              move_inc = 1'b1;
            end else if (resp == DONE_RESP) begin
              cmd_done = 1'b1;
              if (empty) begin
                nxt      = S_IDLE;
                seq_done = 1'b1;
              end else begin
                nxt = S_LOAD;
              end
            end else begin
              err_set = 1'b1;
              nxt     = S_IDLE;
            end
          end else if (tmo_hit) begin
            err_set    = 1'b1;
            fifo_flush = 1'b1;
            nxt        = S_IDLE;
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cmd      <= '0;
      move_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= nxt;
      if (fifo_pop) begin
        cmd      <= head;
        move_cnt <= '0;
      end else if (move_inc && move_cnt != 8'hFF) begin
        move_cnt <= move_cnt + 1'b1;
      end
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmd_seq_queue.sv
// tb/tb_cmd_seq_queue.sv - randomized scoreboard bench for cmd_seq_queue
module tb_cmd_seq_queue;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0, start = 1'b0, abort = 1'b0;
  logic        cmd_sent = 1'b0, resp_rdy = 1'b0;
  logic [15:0] push_cmd = '0;
  logic [7:0]  resp = '0;
  logic        full, empty, send_cmd, clr_resp_rdy, busy, cmd_done, seq_done, err;
  logic [3:0]  count;
  logic [15:0] cmd;
  logic [7:0]  move_cnt;

  int          n_pass = 0, n_total = 0;
  logic [15:0] model_q[$];
  logic [15:0] exp_send_q[$];
  int          exp_done_q[$];
  int          exp_seq = 0;
  logic [7:0]  resp_bytes[$];
  bit          auto_sent = 1'b1, auto_resp = 1'b1;
  logic [15:0] last_sent = '0;

  always #5 clk = ~clk;

  cmd_seq_queue #(
    .DEPTH(DEPTH)
`ifdef CMD_SEQ_TIMEOUT_EN
    , .TMO_CYC(100)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_cmd(push_cmd), .start(start),
    .abort(abort), .full(full), .empty(empty), .count(count), .send_cmd(send_cmd),
    .cmd(cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
    .clr_resp_rdy(clr_resp_rdy), .busy(busy), .cmd_done(cmd_done),
    .seq_done(seq_done), .move_cnt(move_cnt), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (send_cmd) begin
        if (exp_send_q.size() == 0) check("unexpected_send_cmd", send_cmd, 0);
        else check("send_order", cmd, exp_send_q.pop_front());
        last_sent = cmd;
      end
      if (cmd_done) begin
        check("cmd_stable_at_done", cmd, last_sent);
        if (exp_done_q.size() == 0) check("unexpected_cmd_done", cmd_done, 0);
        else check("move_cnt_at_done", move_cnt, exp_done_q.pop_front());
      end
      if (seq_done) begin
        if (exp_seq == 0) check("unexpected_seq_done", seq_done, 0);
        else begin
          exp_seq--;
          check("seq_done", seq_done, 1);
        end
      end
      if (resp_rdy) check("clr_resp_rdy", clr_resp_rdy, 1);
    end
  end

  // RemoteComm responder
  initial begin
    logic [7:0] b;
    bit term;
    forever begin
      @(negedge clk);
      if (send_cmd && auto_sent) begin
        @(posedge clk);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 cmd_sent = 1'b1;
        @(posedge clk);
        #1 cmd_sent = 1'b0;
        term = 1'b0;
        while (auto_resp && !term && resp_bytes.size() > 0) begin
          b = resp_bytes.pop_front();
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1 resp = b;
          resp_rdy = 1'b1;
          @(posedge clk);
          #1 resp_rdy = 1'b0;
          term = (b != 8'h5A);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [15:0] c);
    push = 1'b1;
    push_cmd = c;
    tick();
    push = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(c);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("idle_timeout", busy, 0);
  endtask

  task automatic load_script(input logic [15:0] c, input int mv);
    exp_send_q.push_back(c);
    exp_done_q.push_back(mv > 255 ? 255 : mv);
    repeat (mv) resp_bytes.push_back(8'h5A);
    resp_bytes.push_back(8'hA5);
  endtask

  function automatic logic [15:0] rand_cmd();
    logic [15:0] c = 16'($urandom);
    c[15:12] = 4'(4 + $urandom_range(0, 2));
    return c;
  endfunction

  task automatic drain(input int lo, input int hi);
    foreach (model_q[i]) load_script(model_q[i], $urandom_range(lo, hi));
    model_q.delete();
    exp_seq++;
    pulse_start();
    check("err_clear_on_start", err, 0);
    wait_idle(3000);
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);
    check("drain_err", err, 0);
  endtask

  initial begin
    logic [15:0] t1[4];
    logic [15:0] c;
    int n;
    t1 = '{16'h4001, 16'h4BF1, 16'h47F1, 16'h43F1};
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_send_cmd", send_cmd, 0);
    check("rst_err", err, 0);
    check("rst_move_cnt", move_cnt, 0);
    check("rst_cmd", cmd, 0);
    rst_n = 1'b1;
    tick();

    foreach (t1[i]) do_push(t1[i]);
    check("t1_count", count, 4);
    drain(0, 0);

    do_push(16'h6022);
    drain(24, 24);

    do_push(16'h6000 | 16'($urandom_range(0, 4095)));
    drain(260, 260);

    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) do_push(rand_cmd());
      check("rand_count", count, n);
      drain(0, 6);
    end

    exp_seq++;
    pulse_start();
    check("empty_start_busy", busy, 0);

    for (int k = 0; k <= DEPTH; k++) do_push(rand_cmd());
    check("t3_full", full, 1);
    check("t3_count", count, DEPTH);
    foreach (model_q[i]) load_script(model_q[i], 0);
    model_q.delete();
    c = rand_cmd();
    load_script(c, 0);
    exp_seq++;
    pulse_start();
    push = 1'b1;
    push_cmd = c;
    tick();
    push = 1'b0;
    check("t3_pushpop_count", count, DEPTH);
    check("t3_pushpop_full", full, 1);
    wait_idle(3000);
    check("t3_final_count", count, 0);

    for (int k = 0; k < 3; k++) do_push(rand_cmd());
    exp_send_q.push_back(model_q[0]);
    exp_send_q.push_back(model_q[1]);
    exp_done_q.push_back(0);
    resp_bytes.push_back(8'hA5);
    resp_bytes.push_back(8'h33);
    void'(model_q.pop_front());
    void'(model_q.pop_front());
    pulse_start();
    wait_idle(500);
    check("t4_err", err, 1);
    check("t4_busy", busy, 0);
    check("t4_count", count, 1);
    drain(0, 2);

    auto_sent = 1'b0;
    for (int k = 0; k < 4; k++) do_push(rand_cmd());
    exp_send_q.push_back(model_q[0]);
    model_q.delete();
    pulse_start();
    tick();
    tick();
    check("t5_busy_wait_sent", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_empty", empty, 1);
    check("t5_err", err, 0);
    repeat (20) tick();

    do_push(rand_cmd());
    model_q.delete();
    pulse_start();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_send_busy", busy, 0);
    check("abort_send_empty", empty, 1);
    repeat (10) tick();
    auto_sent = 1'b1;

`ifdef CMD_SEQ_TIMEOUT_EN
    auto_resp = 1'b0;
    do_push(rand_cmd());
    do_push(rand_cmd());
    exp_send_q.push_back(model_q[0]);
    model_q.delete();
    pulse_start();
    n = 0;
    while (!err && n < 400) begin
      tick();
      n++;
    end
    check("t6_tmo_window", (n >= 103 && n <= 106), 1);
    check("t6_err", err, 1);
    check("t6_empty", empty, 1);
    check("t6_busy", busy, 0);
    repeat (10) tick();
    auto_resp = 1'b1;
`endif

    repeat (5) tick();
    check("sb_send_left", exp_send_q.size(), 0);
    check("sb_done_left", exp_done_q.size(), 0);
    check("sb_seq_left", exp_seq, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
